// File: rtl/nec_ir_pkg.sv
// Shared types and timing windows (microseconds) for the NEC IR receiver.
package nec_ir_pkg;

    localparam int unsigned WIDTH_W    = 14;
    localparam int unsigned WIDTH_MAX  = 16383;
    localparam int unsigned TIMEOUT_US = 11000;

    localparam int unsigned FRAME_BITS = 32;
    localparam int unsigned BIT_CNT_W  = 5;

    localparam int unsigned LEAD_MARK_MIN  = 8000;
    localparam int unsigned LEAD_MARK_MAX  = 10000;
    localparam int unsigned LEAD_SPACE_MIN = 4000;
    localparam int unsigned LEAD_SPACE_MAX = 5000;
    localparam int unsigned RPT_SPACE_MIN  = 2000;
    localparam int unsigned RPT_SPACE_MAX  = 2500;
    localparam int unsigned BIT_MARK_MIN   = 400;
    localparam int unsigned BIT_MARK_MAX   = 700;
    localparam int unsigned ZERO_SPACE_MIN = 400;
    localparam int unsigned ZERO_SPACE_MAX = 700;
    localparam int unsigned ONE_SPACE_MIN  = 1400;
    localparam int unsigned ONE_SPACE_MAX  = 1900;
    localparam int unsigned STOP_MARK_MIN  = 400;
    localparam int unsigned STOP_MARK_MAX  = 700;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        RPT_STOP
    } state_t;

    // Received frame; first bit on air lands in addr_lo[0].
    typedef struct packed {
        logic [7:0] cmd_inv;
        logic [7:0] cmd;
        logic [7:0] addr_hi;
        logic [7:0] addr_lo;
    } nec_frame_t;

    function automatic logic in_window(input logic [WIDTH_W-1:0] w,
                                       input int unsigned lo,
                                       input int unsigned hi);
        return (w >= WIDTH_W'(lo)) && (w <= WIDTH_W'(hi));
    endfunction

endpackage

// File: rtl/ir_input_filter.sv
// Synchroniser, glitch filter and edge detector for the raw IR demodulator pin.
module ir_input_filter #(
    parameter int unsigned GLITCH_CYC = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ir_in,
    output logic lvl,
    output logic rise,
    output logic fall
);

    localparam int unsigned CNT_W = 8;

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= ir_in;
            sync2 <= sync1;
        end
    end

    // Level follows the synchronised input only after GLITCH_CYC agreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl  <= 1'b1;
            cnt  <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync2 != lvl) begin
                if (cnt == CNT_W'(GLITCH_CYC - 1)) begin
                    lvl  <= sync2;
                    rise <= sync2;
                    fall <= ~sync2;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/nec_ir_decoder.sv
// NEC IR receiver: microsecond width measurement and frame/repeat decoding FSM.
module nec_ir_decoder
    import nec_ir_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned GLITCH_CYC = 8,
    parameter int unsigned EXT_ADDR   = 0,
    parameter int unsigned REPEAT_EN  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ir_in,
    output logic [15:0] address,
    output logic [7:0]  command,
    output logic        valid,
    output logic        rpt,
    output logic        error,
    output logic        busy
);

    localparam int unsigned DIV   = CLK_HZ / 1_000_000;
    localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic lvl;
    logic rise;
    logic fall;
    logic lvl_edge;
    logic mark_end;
    logic space_end;

    logic [PRE_W-1:0]   presc;
    logic [WIDTH_W-1:0] width;

    state_t                 state_q, state_d;
    nec_frame_t             frame_q, frame_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                   have_frame_q, have_frame_d;
    logic [15:0]            address_d;
    logic [7:0]             command_d;
    logic                   valid_d, rpt_d, error_d;
    logic                   abort;
    logic                   frame_ok;

    ir_input_filter #(
        .GLITCH_CYC(GLITCH_CYC)
    ) u_filter (
        .clk  (clk),
        .rst  (rst),
        .ir_in(ir_in),
        .lvl  (lvl),
        .rise (rise),
        .fall (fall)
    );

    assign lvl_edge  = rise | fall;
    assign mark_end  = lvl_edge & lvl;
    assign space_end = lvl_edge & ~lvl;

    // Prescaler restarts on every edge so each width is measured edge-aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            width <= '0;
        end else if (lvl_edge) begin
            presc <= PRE_W'(DIV - 1);
            width <= '0;
        end else if (presc == PRE_W'(DIV - 1)) begin
            presc <= '0;
            if (width != WIDTH_W'(WIDTH_MAX)) begin
                width <= width + WIDTH_W'(1);
            end
        end else begin
            presc <= presc + PRE_W'(1);
        end
    end

    assign frame_ok = (frame_q.cmd_inv == ~frame_q.cmd) &&
                      ((EXT_ADDR != 0) || (frame_q.addr_hi == ~frame_q.addr_lo));

    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        bit_cnt_d    = bit_cnt_q;
        have_frame_d = have_frame_q;
        address_d    = address;
        command_d    = command;
        valid_d      = 1'b0;
        rpt_d        = 1'b0;
        error_d      = 1'b0;
        abort        = 1'b0;

        // Timeout takes priority over any edge in the same cycle.
        if (state_q != IDLE && width >= WIDTH_W'(TIMEOUT_US)) begin
            abort = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (space_end) state_d = LEAD_MARK;
                end
                LEAD_MARK: begin
                    if (mark_end) begin
                        if (in_window(width, LEAD_MARK_MIN, LEAD_MARK_MAX)) state_d = LEAD_SPACE;
                        else abort = 1'b1;
                    end
                end
                LEAD_SPACE: begin
                    if (space_end) begin
                        if (in_window(width, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
                            bit_cnt_d = '0;
                            state_d   = BIT_MARK;
                        end else if ((REPEAT_EN != 0) && have_frame_q &&
                                     in_window(width, RPT_SPACE_MIN, RPT_SPACE_MAX)) begin
                            state_d = RPT_STOP;
                        end else begin
                            abort = 1'b1;
                        end
                    end
                end
                BIT_MARK: begin
                    if (mark_end) begin
                        if (in_window(width, BIT_MARK_MIN, BIT_MARK_MAX)) state_d = BIT_SPACE;
                        else abort = 1'b1;
                    end
                end
                BIT_SPACE: begin
                    if (space_end) begin
                        if (in_window(width, ZERO_SPACE_MIN, ZERO_SPACE_MAX) ||
                            in_window(width, ONE_SPACE_MIN, ONE_SPACE_MAX)) begin
                            frame_d   = nec_frame_t'({in_window(width, ONE_SPACE_MIN, ONE_SPACE_MAX),
                                                      frame_q[31:1]});
                            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                            if (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1)) state_d = STOP_MARK;
                            else state_d = BIT_MARK;
                        end else begin
                            abort = 1'b1;
                        end
                    end
                end
                STOP_MARK: begin
                    if (mark_end) begin
                        if (in_window(width, STOP_MARK_MIN, STOP_MARK_MAX)) begin
                            state_d = IDLE;
                            if (frame_ok) begin
                                address_d    = (EXT_ADDR != 0) ? {frame_q.addr_hi, frame_q.addr_lo}
                                                               : {8'h00, frame_q.addr_lo};
                                command_d    = frame_q.cmd;
                                valid_d      = 1'b1;
                                have_frame_d = 1'b1;
                            end else begin
                                error_d      = 1'b1;
                                have_frame_d = 1'b0;
                            end
                        end else begin
                            abort = 1'b1;
                        end
                    end
                end
                RPT_STOP: begin
                    if (mark_end) begin
                        if (in_window(width, STOP_MARK_MIN, STOP_MARK_MAX)) begin
                            rpt_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            abort = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (abort) begin
            error_d      = 1'b1;
            have_frame_d = 1'b0;
            state_d      = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            frame_q      <= '0;
            bit_cnt_q    <= '0;
            have_frame_q <= 1'b0;
            address      <= '0;
            command      <= '0;
            valid        <= 1'b0;
            rpt          <= 1'b0;
            error        <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            bit_cnt_q    <= bit_cnt_d;
            have_frame_q <= have_frame_d;
            address      <= address_d;
            command      <= command_d;
            valid        <= valid_d;
            rpt          <= rpt_d;
            error        <= error_d;
            busy         <= (state_d != IDLE);
        end
    end

endmodule

// File: doc/nec_ir_decoder.md
# nec_ir_decoder

Parametrised NEC infrared remote-control receiver sitting between the IR demodulator pin and the command-handling logic. It synchronises and deglitches the raw input, then measures mark/space widths in microseconds independent of the clock frequency. It decodes standard or extended-address NEC frames and repeat codes, and reports each result as a single-cycle pulse with address, command and error status.

## Interface
- `CLK_HZ`, 50_000_000: clock frequency. `CLK_HZ/1_000_000` must be an integer ≥ 2.
- `GLITCH_CYC`, 8: consecutive identical synchronised samples required before the filtered level changes. Range 1..255.
- `EXT_ADDR`, 0:
  - 0: the address byte must equal the inverse of the byte that follows it; `address[15:8]` is driven 0.
  - 1: both address bytes are taken as a 16-bit address with no inversion check.
- `REPEAT_EN`, 1: 0 treats a repeat leader as an error.
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `ir_in`, input, 1: raw demodulator output, asynchronous. Low means carrier (mark); high means space or idle.
- `address`, output, 16: address of the last valid frame.
- `command`, output, 8: command of the last valid frame.
- `valid`, output, 1: one-cycle pulse when a new frame is accepted.
- `repeat`, output, 1: one-cycle pulse when a repeat code is accepted.
- `error`, output, 1: one-cycle pulse when a frame is aborted or rejected.
- `busy`, output, 1: high whenever the FSM is not in IDLE.

## Operation
- **Input path.**
  - Two-flop synchroniser, reset value 1.
  - Glitch filter, reset value 1.
  - Edge detector on the filtered level `lvl`.
- **Microsecond timing.**
  - A prescaler generates a 1 µs tick.
  - A 14-bit width counter counts ticks since the last `lvl` edge and saturates at 16383.
  - On each `lvl` edge, the counter value is the width of the level just ended; the counter then clears to 0.
- **FSM states and transitions:**
  - IDLE: a falling edge of `lvl` goes to LEAD_MARK.
  - LEAD_MARK: on the rising edge, a width of 8000..10000 goes to LEAD_SPACE.
  - LEAD_SPACE: on the falling edge:
    - 4000..5000: clear the bit counter and go to BIT_MARK.
    - 2000..2500 with `REPEAT_EN` and `have_frame` set: go to RPT_STOP.
  - BIT_MARK: on the rising edge, a width of 400..700 goes to BIT_SPACE.
  - BIT_SPACE: on the falling edge:
    - 400..700 shifts in 0.
    - 1400..1900 shifts in 1.
    - After the 32nd bit, go to STOP_MARK; otherwise go to BIT_MARK.
  - STOP_MARK: on the rising edge, a width of 400..700 triggers the frame check, then IDLE.
  - RPT_STOP: on the rising edge, a width of 400..700 pulses `repeat`, then IDLE.
- **Abort conditions.**
  - Any width outside its window pulses `error` and returns to IDLE.
  - In any non-IDLE state, a width counter reaching 11000 pulses `error` and returns to IDLE.
- **Bit order.** LSB first: the first data bit received is `data[0]`. Byte layout: `[7:0]` addr_lo, `[15:8]` addr_hi or ~addr_lo, `[23:16]` cmd, `[31:24]` ~cmd.
- **Frame check.**
  - Passes when `data[31:24] == ~data[23:16]` and, if `EXT_ADDR`=0, `data[15:8] == ~data[7:0]`.
  - Pass: load `address` and `command`, pulse `valid`, set `have_frame`.
  - Fail: pulse `error` and clear `have_frame`. `address` and `command` are unchanged.
- **`have_frame`.** Cleared by reset and by any `error`.

## Timing
- **Reset values.** All outputs 0; FSM in IDLE; `have_frame` 0; width counter and prescaler 0.
- **Reset mid-frame.** Takes effect on the next edge. No `valid`, `repeat` or `error` pulse is produced for the abandoned frame.
- **Input latency.** An `ir_in` transition, held stable, changes `lvl` `GLITCH_CYC`+2 cycles later.
- **Output latency.** `valid`, `repeat` and `error` assert 1 cycle after the `lvl` edge that decides them. The total from the `ir_in` edge is `GLITCH_CYC`+3 cycles.
- **Output timing.** `address` and `command` update in the same cycle `valid` rises.
- **Pulse exclusivity.** At most one of `valid`, `repeat`, `error` is high in any cycle; each stays high exactly 1 cycle.
- **Window boundaries.** All window limits are inclusive.
- **Measurement error.** Widths carry ±1 µs of prescaler-phase error; the windows absorb it.
- **Timeout vs. edge.** If a timeout and an edge fall in the same cycle, the timeout wins.

## Structure
- **Package `nec_ir_pkg`:**
  - State enum: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, RPT_STOP.
  - Window min/max constants in µs.
  - Timeout constant 11000.
  - Width-counter width constant 14.
- **Sub-module `ir_input_filter`:** contains the synchroniser, glitch filter and edge detector. Outputs `lvl`, `rise` and `fall`.

## Test plan
- **Valid frame.** Frame with addr 0x00, cmd 0x45, all nominal widths (9000/4500/560/560 or 1690), `EXT_ADDR`=0 -> one `valid` pulse, `address`=0x0000, `command`=0x45, no `error`.
- **Repeat code.** 9000 mark, 2250 space, 560 mark, sent 40 ms after the valid frame above -> one `repeat` pulse, `command` still 0x45. The same repeat sent after reset -> `error`.
- **Bad inverse.** Frame whose cmd inverse byte is 0xBB instead of 0xBA -> `error` pulse, outputs unchanged. A following repeat -> `error`.
- **Extended address.** `EXT_ADDR`=1, addr bytes 0x12, 0x34 -> `valid`, `address`=0x3412.
- **Glitch and window limits.**
  - A 5-cycle low glitch on idle input with `GLITCH_CYC`=8 -> `busy` stays 0.
  - A bit space of 1901 µs -> `error`.
  - A bit space of 1900 µs -> decoded as 1.
- **Timeout and reset.**
  - Input stuck low 12 ms after a valid leader -> `error` at the 11000 µs count.
  - `rst` asserted after bit 16 -> `busy`=0 on the next cycle, no pulses.
